instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Write-side counterpart of the instruction memory: receives a program image as a byte stream and produces word writes (enable, byte address, data) into the instruction memory array.
- Replaces the simulation-only hex-file preload with a synthesizable boot path.
- Holds the pipeline in stall through `cpu_hold` until the image is fully written.

Parameters:
- WIDTH, 32, instruction word width in bits; must be a multiple of 8 (BYTES = WIDTH/8).
- DEPTH, 100, instruction memory depth in words; upper bound on the image length.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a load; ignored unless state is IDLE or DONE.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  one-cycle instruction-memory write strobe.
- wr_addr  output  WIDTH  byte address, word aligned (memory index = wr_addr >> 2).
- wr_data  output  WIDTH  assembled instruction word.
- cpu_hold  output  1  pipeline stall/hold request while loading.
- done  output  1  load completed successfully; sticky until next start or reset.
- load_err  output  1  load aborted; sticky until next start or reset.
- word_count  output  16  words written in the current load.

Behaviour:
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, load_err=0, word_count=0, state=IDLE.
  - Any partial length or partial word is discarded on reset, including mid-load.
- Byte transfer occurs on a rising edge when byte_valid && byte_ready.
  - byte_ready=1 only in LEN_HI, LEN_LO, DATA (and CSUM with the optional feature).
- States:
  - IDLE: cpu_hold=1. start -> LEN_HI; clears done, load_err, word_count, wr_addr, length register.
  - LEN_HI: accept byte -> N[15:8]; go to LEN_LO.
  - LEN_LO: accept byte -> N[7:0]; then:
    - if N==0 -> DONE (no writes);
    - if N>DEPTH -> ERR;
    - else -> DATA, byte index 0.
  - DATA: accept BYTES bytes, big-endian (first byte -> wr_data[WIDTH-1:WIDTH-8]). After the last byte of a word -> WRITE.
    - Gaps in byte_valid are allowed at any point with no loss.
  - WRITE: exactly one cycle. wr_en=1, byte_ready=0. wr_addr = 4*word_count, wr_data = assembled word. Next edge: word_count+1, wr_addr+4.
    - If word_count+1==N -> DONE (or CSUM with the feature); else -> DATA.
  - DONE: done=1, cpu_hold=0, byte_ready=0. start -> LEN_HI (reload).
  - ERR: load_err=1, cpu_hold=1, byte_ready=0, no further writes. start -> LEN_HI.
- Latency: wr_en is asserted the cycle after the edge that accepts the last byte of a word. Minimum BYTES+1 cycles per word.
- start while in LEN_HI/LEN_LO/DATA/WRITE is ignored.
- start in the same cycle as a byte_valid in IDLE/DONE: the byte is not consumed (byte_ready=0 that cycle).
- wr_addr never exceeds 4*(DEPTH-1) because N is checked against DEPTH before any write.
- wr_en is never asserted outside WRITE; wr_addr/wr_data hold their last values otherwise.

Optional Feature:
- Macro: INSTR_MEM_LOADER_CHECKSUM_EN
- Defined:
  - After the Nth WRITE (or after LEN_LO when N==0), enter CSUM and accept one byte.
  - The byte must equal the XOR of all accepted data bytes (0x00 when N==0).
  - Match -> DONE; mismatch -> ERR. Words already written remain in memory but done stays 0.
- Undefined: no CSUM state, no trailing byte; the XOR accumulator is not built.

Test Plan:
- Load N=3: bytes 00 03, 20 08 00 05, 20 09 00 0A, 01 09 50 20 -> writes (0x0,0x20080005), (0x4,0x2009000A), (0x8,0x01095020); done=1, cpu_hold=0, word_count=3.
- Byte_valid toggled every other cycle during the N=3 load -> identical writes; exactly 3 wr_en pulses, each lasting one cycle.
- N=0 (00 00) -> DONE with zero wr_en pulses; N=101 with DEPTH=100 (00 65) -> load_err=1, cpu_hold=1, no wr_en.
- rst_n low after 2 bytes of word 1 of an N=2 load -> all outputs at reset values immediately. A new start plus a full N=1 image writes at address 0x0.
- start pulsed mid-DATA -> ignored, load completes normally. start after DONE -> done clears, second image overwrites from address 0x0.
- With INSTR_MEM_LOADER_CHECKSUM_EN: N=1 word 12 34 56 78 plus byte 0x08 -> done=1. Same word plus byte 0x09 -> load_err=1, word still written at 0x0.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input / instruction-memory write output bundle for instr_mem_loader.
// master = boot host / memory side, slave = the loader itself.
interface instr_mem_loader_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             wr_en;
    logic [WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             cpu_hold;
    logic             done;
    logic             load_err;
    logic [15:0]      word_count;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, load_err, word_count
    );
    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, load_err, word_count
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot loader: length-prefixed big-endian byte stream -> instruction memory word writes.
// Optional trailing XOR checksum byte when INSTR_MEM_LOADER_CHECKSUM_EN is defined.
module instr_mem_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_mem_loader_if.slave bus
);
    localparam int BYTES = WIDTH / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd7;
    localparam logic [2:0] S_END    = S_CSUM;
`else
    localparam logic [2:0] S_END    = S_DONE;
`endif

    logic [2:0]       state;
    logic [15:0]      len;
    logic [BW-1:0]    byte_idx;
    logic [WIDTH-1:0] word_sr;
    logic [WIDTH-1:0] wr_addr_q;
    logic [WIDTH-1:0] wr_data_q;
    logic [15:0]      word_count_q;
    logic             byte_ready;
    logic             xfer;
    logic [15:0]      len_next;
    logic [15:0]      wc_inc;
    logic [WIDTH-1:0] sr_next;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    always_comb begin
        byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        if (state == S_CSUM) byte_ready = 1'b1;
`endif
    end

    assign xfer     = bus.byte_valid && byte_ready;
    assign len_next = {len[15:8], bus.byte_in};
    assign wc_inc   = word_count_q + 16'd1;
    // First byte of a word ends up in the MSB after BYTES shifts.
    assign sr_next  = (word_sr << 8) | WIDTH'(bus.byte_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            len          <= '0;
            byte_idx     <= '0;
            word_sr      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            word_count_q <= '0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        state        <= S_LEN_HI;
                        len          <= '0;
                        byte_idx     <= '0;
                        wr_addr_q    <= '0;
                        word_count_q <= '0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                        csum         <= '0;
`endif
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= bus.byte_in;
                        state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= bus.byte_in;
                        byte_idx <= '0;
                        // Length is bounded here so no write can ever address past DEPTH-1.
                        if (len_next == 16'd0)
                            state <= S_END;
                        else if (32'(len_next) > 32'(DEPTH))
                            state <= S_ERR;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        word_sr <= sr_next;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                        csum    <= csum ^ bus.byte_in;
`endif
                        if (byte_idx == BW'(BYTES - 1)) begin
                            byte_idx  <= '0;
                            wr_data_q <= sr_next;
                            wr_addr_q <= WIDTH'({word_count_q, 2'b00});
                            state     <= S_WRITE;
                        end else begin
                            byte_idx <= byte_idx + BW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    word_count_q <= wc_inc;
                    state        <= (wc_inc == len) ? S_END : S_DATA;
                end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (xfer) state <= (bus.byte_in == csum) ? S_DONE : S_ERR;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.wr_en      = (state == S_WRITE);
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.cpu_hold   = (state != S_DONE);
    assign bus.done       = (state == S_DONE);
    assign bus.load_err   = (state == S_ERR);
    assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboarded random-stimulus bench for instr_mem_loader (honours INSTR_MEM_LOADER_CHECKSUM_EN).
`timescale 1ns/1ps
module tb_instr_mem_loader;
    localparam int WIDTH = 32;
    localparam int DEPTH = 100;
    localparam int BYTES = WIDTH / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    instr_mem_loader_if #(.WIDTH(WIDTH)) bus ();
    instr_mem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    wr_t              exp_q[$];
    logic [WIDTH-1:0] img[$];
    int               n_checks  = 0;
    int               n_fail    = 0;
    int               wr_pulses = 0;
    logic             mon_prev  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.wr_en === 1'b1) begin
                wr_pulses++;
                check("wr_en_single_cycle", 64'(mon_prev), 64'd0);
                check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                    check("wr_data", 64'(bus.wr_data), 64'(e.data));
                end
            end
            mon_prev = bus.wr_en;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int gap_of(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap, input bit st);
        bit ok;
        ok = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
            bus.start      = 1'b0;
            bus.byte_in    = 8'($urandom);
        end
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        bus.start      = st;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (t > 0) @(negedge clk);
            ok = (bus.byte_ready === 1'b1);
            @(posedge clk);
        end
        check("byte_accepted", 64'(ok), 64'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start      = 1'b1;
        bus.byte_valid = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
        check({tag, "_wr_en"},      64'(bus.wr_en),      64'd0);
        check({tag, "_wr_addr"},    64'(bus.wr_addr),    64'd0);
        check({tag, "_wr_data"},    64'(bus.wr_data),    64'd0);
        check({tag, "_cpu_hold"},   64'(bus.cpu_hold),   64'd1);
        check({tag, "_done"},       64'(bus.done),       64'd0);
        check({tag, "_load_err"},   64'(bus.load_err),   64'd0);
        check({tag, "_word_count"}, 64'(bus.word_count), 64'd0);
    endtask

    task automatic wait_end(input bit exp_ok, input int exp_wc, input int base, input int exp_wr);
        int t;
        t = 0;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.start      = 1'b0;
        while (!(bus.done === 1'b1 || bus.load_err === 1'b1) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("end_reached",    64'(t < 300),                 64'd1);
        check("done",           64'(bus.done),                64'(exp_ok));
        check("load_err",       64'(bus.load_err),            64'(!exp_ok));
        check("cpu_hold",       64'(bus.cpu_hold),            64'(!exp_ok));
        check("word_count",     64'(bus.word_count),          64'(exp_wc));
        check("byte_ready_end", 64'(bus.byte_ready),          64'd0);
        check("write_pulses",   64'(wr_pulses - base),        64'(exp_wr));
        check("queue_drained",  64'(exp_q.size()),           64'd0);
    endtask

    // Reference: an image of n words lands at 4*i; n==0 or n<=DEPTH succeeds, n>DEPTH aborts
    // before any write; with the checksum option a wrong trailing XOR byte fails after writing.
    task automatic run_load(input int n, input int gap_mode, input int mid_start,
                            input int csum_delta, input bit do_start);
        logic [15:0]      nl;
        logic [7:0]       x;
        logic [WIDTH-1:0] w;
        int               base, bi, ex_wr;
        bit               fits, exp_ok;
        nl     = 16'(n);
        x      = 8'h00;
        base   = wr_pulses;
        bi     = 0;
        fits   = (n <= DEPTH);
        ex_wr  = fits ? n : 0;
        exp_ok = fits;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        if (fits && csum_delta != 0) exp_ok = 1'b0;
`endif
        for (int i = 0; i < ex_wr; i++)
            exp_q.push_back('{addr: WIDTH'(4 * i), data: img[i]});
        if (do_start) pulse_start();
        send_byte(nl[15:8], gap_of(gap_mode), 1'b0);
        send_byte(nl[7:0],  gap_of(gap_mode), 1'b0);
        for (int i = 0; i < ex_wr; i++) begin
            w = img[i];
            for (int b = 0; b < BYTES; b++) begin
                send_byte(w[WIDTH-1 -: 8], gap_of(gap_mode), bi == mid_start);
                x  = x ^ w[WIDTH-1 -: 8];
                w  = w << 8;
                bi++;
            end
        end
        x = x ^ 8'(csum_delta);
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        if (fits) send_byte(x, gap_of(gap_mode), 1'b0);
`endif
        wait_end(exp_ok, fits ? n : 0, base, ex_wr);
    endtask

    task automatic rand_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(WIDTH'($urandom));
    endtask

    initial begin : stim
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;

        // Reference N=3 image, back-to-back then with every-other-cycle gaps.
        img.delete();
        img.push_back(32'h20080005);
        img.push_back(32'h2009000A);
        img.push_back(32'h01095020);
        run_load(3, 0, -1, 0, 1'b1);
        run_load(3, 1, -1, 0, 1'b1);

        img.delete();
        run_load(0, 0, -1, 0, 1'b1);
        run_load(DEPTH + 1, 0, -1, 0, 1'b1);

        // Reset two bytes into word 0 of an N=2 load.
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'hDE, 0, 1'b0);
        send_byte(8'hAD, 0, 1'b0);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset("midload_rst");
        @(negedge clk);
        rst_n = 1'b1;
        rand_img(1);
        run_load(1, 0, -1, 0, 1'b1);

        // start during DATA must be ignored.
        rand_img(3);
        run_load(3, 2, 5, 0, 1'b1);

        // start from DONE together with a byte: byte not taken, done clears.
        @(negedge clk);
        bus.start      = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h00;
        check("start_byte_not_taken", 64'(bus.byte_ready), 64'd0);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        check("reload_done_clear", 64'(bus.done),     64'd0);
        check("reload_hold",       64'(bus.cpu_hold), 64'd1);
        rand_img(2);
        run_load(2, 0, -1, 0, 1'b0);

        rand_img(DEPTH);
        run_load(DEPTH, 2, -1, 0, 1'b1);

        for (int k = 0; k < 6; k++) begin
            int n;
            n = int'($urandom_range(1, 10));
            rand_img(n);
            run_load(n, 2, -1, 0, 1'b1);
        end

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        img.delete();
        img.push_back(32'h12345678);
        run_load(1, 0, -1, 0, 1'b1);
        run_load(1, 0, -1, 1, 1'b1);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
